flash_arb: RTL
==============

# flash_arb

Two-port round-robin arbiter in front of `flash_ctl` that shares its single user op/read/write interface between two requesters. Captures one op from the winning requester, issues it downstream and holds the grant until the op has fully completed. It then releases the grant and flips priority. Ops with illegal type or byte count are rejected locally and never reach the flash.

## Interface
- `P_MAX_NUM`, 256, largest legal byte count for read/write ops
- `P_TIMEOUT`, 24'd10_000_000, watchdog limit in cycles (used only with `FLASH_ARB_TIMEOUT_EN`)

Ports:
- `i_clk`  in  1  sole clock
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_uN_op_typ`  in  2  op type from requester N (N = 0, 1): 0 erase, 1 read, 2 write, 3 reserved
- `i_uN_op_addr`  in  24  flash address
- `i_uN_op_num`  in  9  byte count
- `i_uN_op_valid`  in  1  op request
- `o_uN_op_ready`  out  1  op accepted when high together with valid
- `o_uN_err`  out  1  one-cycle pulse: op rejected
- `i_uN_write_data` / `_sop` / `_eop` / `_valid`  in  8/1/1/1  write stream
- `o_uN_read_data` / `_sop` / `_eop` / `_valid`  out  8/1/1/1  read stream
- `o_op_typ` / `o_op_addr` / `o_op_num`  out  2/24/9  registered op to `flash_ctl`
- `o_op_valid`  out  1  downstream request
- `i_op_ready`  in  1  `flash_ctl` ready
- `o_write_data` / `_sop` / `_eop` / `_valid`  out  8/1/1/1  muxed write stream
- `i_read_data` / `_sop` / `_eop` / `_valid`  in  8/1/1/1  read stream from `flash_ctl`
- `o_grant`  out  1  index of the current owner; valid while `o_busy` is high
- `o_busy`  out  1  high when the state is anything other than IDLE

## Operation
- States: IDLE, CHECK, ISSUE, WAIT_DONE, ERR.
- **IDLE:**
  - Winner is the valid requester. If both are valid, the winner is the one at the `rr_ptr` index.
  - `o_uN_op_ready` is combinational: (state == IDLE) & (winner == N).
  - On handshake, capture typ/addr/num, set the owner, then go to CHECK.
- **CHECK:** the op is illegal if typ == 3, or if typ is 1 or 2 and (num == 0 or num > `P_MAX_NUM`). Erase ignores num. Illegal goes to ERR; otherwise go to ISSUE.
- **ERR:** pulse `o_uN_err` of the owner for 1 cycle. Go to IDLE and flip `rr_ptr`.
- **ISSUE:** `o_op_valid` = 1. Captured fields are driven on `o_op_*`. When `i_op_ready` is high, go to WAIT_DONE.
- **WAIT_DONE:**
  - Set `seen_low` when `i_op_ready` is low. Set `seen_eop` on `i_read_eop & i_read_valid`.
  - Done when `seen_low` & `i_op_ready` & (typ != 1 | `seen_eop`).
  - On done, clear both flags, set `rr_ptr` = ~owner, and go to IDLE.
- **Write mux:** `o_write_*` = owner's `i_uN_write_*` while the state is ISSUE or WAIT_DONE; otherwise all zero. The non-owner's write stream is ignored.
- **Read demux:** `o_uN_read_*` = `i_read_*` when N == owner and the state is WAIT_DONE; otherwise all zero.
- **Reset** (async on `i_rst_n` low, any state): state IDLE, `rr_ptr` = 0, flags cleared, every registered output 0. An in-flight downstream op is abandoned; the requester must reissue it.

## Timing
- Accept-to-downstream-valid latency: 2 cycles (IDLE→CHECK→ISSUE). `o_op_*` are registered.
- Reject latency: the `o_uN_err` pulse appears 2 cycles after acceptance.
- `o_op_valid` stays high until `i_op_ready` is seen; the fields are stable throughout.
- At most one op is outstanding. No requester is accepted again before the owner's op completes.
- If both requesters hold valid continuously, grants alternate 0,1,0,1,…
- Read/write muxes are combinational: zero added latency.
- Reset values: all `o_*` are 0, including `o_uN_op_ready` (which is 0 during reset and 0 in IDLE while no valid is present).

## Configuration
- `FLASH_ARB_TIMEOUT_EN` defined:
  - A 24-bit counter runs in ISSUE/WAIT_DONE and clears on state entry.
  - When it reaches `P_TIMEOUT`, the arbiter pulses the owner's `o_uN_err` for 1 cycle, drops `o_op_valid`, goes to IDLE and flips `rr_ptr`.
- Undefined: no counter. WAIT_DONE waits indefinitely.

## Test plan
- u0 read, addr 0x000100, num 4. Stub returns 4 bytes with sop/eop, then ready → `o_u0_read_*` carries the 4 bytes, `o_u1_read_valid` stays 0, and the arbiter is in IDLE again 1 cycle after done.
- u0 and u1 both valid in the same cycle after reset, each issuing erase → u0 is granted first and u1 second. `o_op_addr` order matches.
- u1 write, num 0 → `o_u1_err` pulses 2 cycles after accept, and `o_op_valid` is never asserted.
- u0 write, num 3, data 0xA5/0x5A/0xFF → `o_write_data` mirrors u0 while u1 toggles its write inputs. The op completes on the ready low→high return.
- `i_rst_n` low during WAIT_DONE of a read → all outputs are 0 immediately. After release, a new u1 request is accepted (`rr_ptr` = 0, u0 idle).
- `FLASH_ARB_TIMEOUT_EN` defined, `P_TIMEOUT` = 100, stub never re-raises ready → owner err pulses at count 100, and the state returns to IDLE.

Source files
------------

// File: rtl/flash_arb.sv
// flash_arb: two-port round-robin arbiter sharing one flash_ctl op/read/write interface.
// Optional watchdog: define FLASH_ARB_TIMEOUT_EN to abort ops stuck longer than P_TIMEOUT cycles.
module flash_arb #(
    parameter int          P_MAX_NUM = 256,
    parameter logic [23:0] P_TIMEOUT = 24'd10_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_u0_op_typ,
    input  logic [23:0] i_u0_op_addr,
    input  logic [8:0]  i_u0_op_num,
    input  logic        i_u0_op_valid,
    output logic        o_u0_op_ready,
    output logic        o_u0_err,
    input  logic [7:0]  i_u0_write_data,
    input  logic        i_u0_write_sop,
    input  logic        i_u0_write_eop,
    input  logic        i_u0_write_valid,
    output logic [7:0]  o_u0_read_data,
    output logic        o_u0_read_sop,
    output logic        o_u0_read_eop,
    output logic        o_u0_read_valid,
    input  logic [1:0]  i_u1_op_typ,
    input  logic [23:0] i_u1_op_addr,
    input  logic [8:0]  i_u1_op_num,
    input  logic        i_u1_op_valid,
    output logic        o_u1_op_ready,
    output logic        o_u1_err,
    input  logic [7:0]  i_u1_write_data,
    input  logic        i_u1_write_sop,
    input  logic        i_u1_write_eop,
    input  logic        i_u1_write_valid,
    output logic [7:0]  o_u1_read_data,
    output logic        o_u1_read_sop,
    output logic        o_u1_read_eop,
    output logic        o_u1_read_valid,
    output logic [1:0]  o_op_typ,
    output logic [23:0] o_op_addr,
    output logic [8:0]  o_op_num,
    output logic        o_op_valid,
    input  logic        i_op_ready,
    output logic [7:0]  o_write_data,
    output logic        o_write_sop,
    output logic        o_write_eop,
    output logic        o_write_valid,
    input  logic [7:0]  i_read_data,
    input  logic        i_read_sop,
    input  logic        i_read_eop,
    input  logic        i_read_valid,
    output logic        o_grant,
    output logic        o_busy
);
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_DONE, ERR} state_t;

    state_t      state_reg, state_next;
    logic        rr_reg, rr_next;
    logic        owner_reg, owner_next;
    logic [1:0]  typ_reg, typ_next;
    logic [23:0] addr_reg, addr_next;
    logic [8:0]  num_reg, num_next;
    logic        seen_low_reg, seen_low_next;
    logic        seen_eop_reg, seen_eop_next;
    logic [1:0]  err_reg, err_next;
    logic        op_valid_reg;
    logic        timeout;
    logic        winner, winner_valid, illegal, wr_sel;

    // Per-requester views so the mux/demux logic can be indexed by owner.
    logic [1:0]  u_typ [2];
    logic [23:0] u_addr [2];
    logic [8:0]  u_num [2];
    logic [1:0]  u_valid;
    logic [7:0]  u_wdata [2];
    logic [1:0]  u_wsop, u_weop, u_wvalid;
    logic [1:0]  op_ready;
    logic [7:0]  rd_data [2];
    logic [1:0]  rd_sop, rd_eop, rd_valid;

    assign u_typ[0]  = i_u0_op_typ;
    assign u_typ[1]  = i_u1_op_typ;
    assign u_addr[0] = i_u0_op_addr;
    assign u_addr[1] = i_u1_op_addr;
    assign u_num[0]  = i_u0_op_num;
    assign u_num[1]  = i_u1_op_num;
    assign u_valid   = {i_u1_op_valid, i_u0_op_valid};
    assign u_wdata[0] = i_u0_write_data;
    assign u_wdata[1] = i_u1_write_data;
    assign u_wsop    = {i_u1_write_sop, i_u0_write_sop};
    assign u_weop    = {i_u1_write_eop, i_u0_write_eop};
    assign u_wvalid  = {i_u1_write_valid, i_u0_write_valid};

    always_comb begin
        winner_valid = |u_valid;
        if (&u_valid) begin
            winner = rr_reg;
        end else begin
            winner = u_valid[1];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic sel;
            // Ready is gated by reset so it reads 0 while the arbiter is held in reset.
            assign op_ready[gi] = i_rst_n & (state_reg == IDLE) & winner_valid & (winner == 1'(gi));
            assign sel          = (state_reg == WAIT_DONE) & (owner_reg == 1'(gi));
            assign rd_data[gi]  = sel ? i_read_data : 8'd0;
            assign rd_sop[gi]   = sel & i_read_sop;
            assign rd_eop[gi]   = sel & i_read_eop;
            assign rd_valid[gi] = sel & i_read_valid;
        end
    endgenerate

    assign illegal = (typ_reg == 2'd3) |
                     (((typ_reg == 2'd1) | (typ_reg == 2'd2)) &
                      ((num_reg == 9'd0) | (32'(num_reg) > 32'(P_MAX_NUM))));

`ifdef FLASH_ARB_TIMEOUT_EN
    logic [23:0] cnt_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg <= 24'd0;
        end else if (state_next != state_reg) begin
            cnt_reg <= 24'd0;
        end else if ((state_reg == ISSUE) || (state_reg == WAIT_DONE)) begin
            cnt_reg <= cnt_reg + 24'd1;
        end
    end

    assign timeout = ((state_reg == ISSUE) || (state_reg == WAIT_DONE)) && (cnt_reg == P_TIMEOUT);
`else
    localparam logic [23:0] unused_timeout = P_TIMEOUT;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        rr_next       = rr_reg;
        owner_next    = owner_reg;
        typ_next      = typ_reg;
        addr_next     = addr_reg;
        num_next      = num_reg;
        seen_low_next = seen_low_reg;
        seen_eop_next = seen_eop_reg;
        err_next      = 2'b00;
        case (state_reg)
            IDLE: begin
                if (winner_valid) begin
                    owner_next = winner;
                    typ_next   = u_typ[winner];
                    addr_next  = u_addr[winner];
                    num_next   = u_num[winner];
                    state_next = CHECK;
                end
            end
            CHECK: state_next = illegal ? ERR : ISSUE;
            ERR: begin
                state_next = IDLE;
                rr_next    = ~rr_reg;
            end
            ISSUE: begin
                if (i_op_ready) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!i_op_ready) seen_low_next = 1'b1;
                if (i_read_eop & i_read_valid) seen_eop_next = 1'b1;
                // flash_ctl signals completion by dropping ready and raising it again.
                if (seen_low_reg & i_op_ready & ((typ_reg != 2'd1) | seen_eop_reg)) begin
                    state_next    = IDLE;
                    seen_low_next = 1'b0;
                    seen_eop_next = 1'b0;
                    rr_next       = ~owner_reg;
                end
            end
            default: state_next = IDLE;
        endcase
        if (timeout) begin
            state_next    = IDLE;
            rr_next       = ~rr_reg;
            seen_low_next = 1'b0;
            seen_eop_next = 1'b0;
            err_next[owner_reg] = 1'b1;
        end
        if (state_next == ERR) err_next[owner_reg] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= IDLE;
            rr_reg       <= 1'b0;
            owner_reg    <= 1'b0;
            typ_reg      <= 2'd0;
            addr_reg     <= 24'd0;
            num_reg      <= 9'd0;
            seen_low_reg <= 1'b0;
            seen_eop_reg <= 1'b0;
            err_reg      <= 2'b00;
            op_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_reg       <= rr_next;
            owner_reg    <= owner_next;
            typ_reg      <= typ_next;
            addr_reg     <= addr_next;
            num_reg      <= num_next;
            seen_low_reg <= seen_low_next;
            seen_eop_reg <= seen_eop_next;
            err_reg      <= err_next;
            op_valid_reg <= (state_next == ISSUE);
        end
    end

    assign wr_sel        = (state_reg == ISSUE) | (state_reg == WAIT_DONE);
    assign o_write_data  = wr_sel ? u_wdata[owner_reg] : 8'd0;
    assign o_write_sop   = wr_sel & u_wsop[owner_reg];
    assign o_write_eop   = wr_sel & u_weop[owner_reg];
    assign o_write_valid = wr_sel & u_wvalid[owner_reg];

    assign o_op_typ   = typ_reg;
    assign o_op_addr  = addr_reg;
    assign o_op_num   = num_reg;
    assign o_op_valid = op_valid_reg;
    assign o_grant    = owner_reg;
    assign o_busy     = (state_reg != IDLE);

    assign o_u0_op_ready   = op_ready[0];
    assign o_u1_op_ready   = op_ready[1];
    assign o_u0_err        = err_reg[0];
    assign o_u1_err        = err_reg[1];
    assign o_u0_read_data  = rd_data[0];
    assign o_u0_read_sop   = rd_sop[0];
    assign o_u0_read_eop   = rd_eop[0];
    assign o_u0_read_valid = rd_valid[0];
    assign o_u1_read_data  = rd_data[1];
    assign o_u1_read_sop   = rd_sop[1];
    assign o_u1_read_eop   = rd_eop[1];
    assign o_u1_read_valid = rd_valid[1];
endmodule
